// File: rtl/core_pkg.sv
// Shared decode definitions for the 32-bit MIPS-subset core: opcode/funct codes,
// control-path encodings, the cpath bundle and the instruction field split.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  // lui has no R-type twin; use an unassigned funct slot as its ALU code
  localparam logic [5:0] FN_LUI   = 6'h3F;

  typedef enum logic [1:0] {
    RSRC_ALU = 2'd0,
    RSRC_MEM = 2'd1
  } reg_src_e;

  typedef enum logic [1:0] {
    RDST_NONE = 2'd0,
    RDST_RD   = 2'd1,
    RDST_RT   = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    ASRC_REG  = 2'd0,
    ASRC_SEXT = 2'd1,
    ASRC_ZEXT = 2'd2
  } alu_src_e;

  typedef struct packed {
    reg_src_e    reg_src;
    reg_dst_e    reg_dst;
    logic        reg_wr;
    logic [5:0]  alu_op;
    alu_src_e    alu_src;
    logic        excp;
  } cpath_t;

  localparam int CPATH_W = $bits(cpath_t);

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } inst_f_t;

  function automatic inst_f_t split_inst(input logic [31:0] inst);
    return inst_f_t'(inst);
  endfunction

endpackage

// File: rtl/decode_rom.sv
// Combinational opcode/funct decoder: control bundle, resolved write index,
// extended immediate and instruction class flags.
module decode_rom
  import core_pkg::*;
(
  input  logic [31:0] inst_i,
  output cpath_t      cpath_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  wr_idx_o,
  output logic [31:0] imm_o,
  output logic        is_branch_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        rt_used_o
);

  inst_f_t     f;
  logic [15:0] imm16;
  cpath_t      cp;
  logic [4:0]  wr_idx;

  assign f     = split_inst(inst_i);
  assign imm16 = {f.rd, f.shamt, f.funct};

  always_comb begin
    cp          = '0;
    is_branch_o = 1'b0;
    is_load_o   = 1'b0;
    is_store_o  = 1'b0;
    rt_used_o   = 1'b0;
    case (f.op)
      OP_RTYPE: begin
        cp.reg_wr  = 1'b1;
        cp.reg_dst = RDST_RD;
        cp.alu_op  = f.funct;
        rt_used_o  = 1'b1;
      end
      OP_J: cp.alu_op = '0;
      OP_BEQ, OP_BNE: begin
        cp.alu_op   = FN_SUB;
        is_branch_o = 1'b1;
        rt_used_o   = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        cp.alu_op   = FN_ADD;
        is_branch_o = 1'b1;
        rt_used_o   = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        cp.reg_wr  = 1'b1;
        cp.reg_dst = RDST_RT;
        cp.alu_src = ASRC_SEXT;
        case (f.op)
          OP_ADDI:  cp.alu_op = FN_ADD;
          OP_ADDIU: cp.alu_op = FN_ADDU;
          OP_SLTI:  cp.alu_op = FN_SLT;
          default:  cp.alu_op = FN_SLTU;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cp.reg_wr  = 1'b1;
        cp.reg_dst = RDST_RT;
        cp.alu_src = ASRC_ZEXT;
        case (f.op)
          OP_ANDI: cp.alu_op = FN_AND;
          OP_ORI:  cp.alu_op = FN_OR;
          OP_XORI: cp.alu_op = FN_XOR;
          default: cp.alu_op = FN_LUI;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        cp.reg_wr  = 1'b1;
        cp.reg_dst = RDST_RT;
        cp.reg_src = RSRC_MEM;
        cp.alu_src = ASRC_SEXT;
        cp.alu_op  = FN_ADD;
        is_load_o  = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        cp.alu_src = ASRC_SEXT;
        cp.alu_op  = FN_ADD;
        is_store_o = 1'b1;
        rt_used_o  = 1'b1;
      end
      default: cp.excp = 1'b1;
    endcase

    wr_idx = 5'd0;
    if (cp.reg_wr) begin
      wr_idx = (cp.reg_dst == RDST_RD) ? f.rd : f.rt;
    end
    // $zero is never a real destination, so a write there is dropped entirely
    if (wr_idx == 5'd0) begin
      cp.reg_wr = 1'b0;
    end
  end

  assign cpath_o  = cp;
  assign wr_idx_o = wr_idx;
  assign rs_o     = f.rs;
  assign rt_o     = f.rt;
  assign imm_o    = (cp.alu_src == ASRC_ZEXT) ? {16'h0000, imm16}
                                              : {{16{imm16[15]}}, imm16};

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// load-use interlock scoreboard and halt-on-illegal-opcode FSM.
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_inst,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CPATH_W-1:0] out_cpath,
  output logic [REG_AW-1:0]  out_rs,
  output logic [REG_AW-1:0]  out_rt,
  output logic [REG_AW-1:0]  out_wr_idx,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_is_branch,
  output logic               out_is_load,
  output logic               out_is_store,
  output logic               halted
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_stage: XLEN must be 32");
  end
  if (REG_AW != 5) begin : g_reg_aw_chk
    $error("decode_stage: REG_AW must be 5");
  end
  if (LOAD_LAT < 0 || LOAD_LAT > 3) begin : g_lat_chk
    $error("decode_stage: LOAD_LAT must be in 0..3");
  end

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam logic [1:0] LAT_C   = 2'(LOAD_LAT);

  logic [0:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        age_q, age_d;
  logic [REG_AW-1:0] ld_idx_q, ld_idx_d;

  cpath_t            cp_q;
  logic [REG_AW-1:0] rs_q, rt_q, wr_idx_q;
  logic [XLEN-1:0]   imm_q, pc_q;
  logic              br_q, ld_q, st_q;

  cpath_t            dec_cp;
  logic [REG_AW-1:0] dec_rs, dec_rt, dec_wr;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_br, dec_ld, dec_st, dec_rt_used;

  logic hazard, in_fire, out_fire;

  decode_rom u_rom (
    .inst_i      (in_inst),
    .cpath_o     (dec_cp),
    .rs_o        (dec_rs),
    .rt_o        (dec_rt),
    .wr_idx_o    (dec_wr),
    .imm_o       (dec_imm),
    .is_branch_o (dec_br),
    .is_load_o   (dec_ld),
    .is_store_o  (dec_st),
    .rt_used_o   (dec_rt_used)
  );

  // A recorded load only ever holds a nonzero index, but $zero sources are
  // excluded explicitly so the interlock never depends on that invariant.
  assign hazard = (age_q != 2'd0) && in_valid &&
                  (((dec_rs != '0) && (dec_rs == ld_idx_q)) ||
                   (dec_rt_used && (dec_rt != '0) && (dec_rt == ld_idx_q)));

  assign in_ready = rst_n && !flush && (state_q == ST_RUN) &&
                    (!out_valid_q || out_ready) && !hazard;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    age_d       = age_q;
    ld_idx_d    = ld_idx_q;
    if (flush) begin
      out_valid_d = 1'b0;
      age_d       = 2'd0;
      state_d     = ST_RUN;
    end else begin
      if (in_fire) begin
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      // a fresh load restarts the countdown even if the old one was expiring
      if (in_fire && dec_ld && (dec_wr != '0)) begin
        ld_idx_d = dec_wr;
        age_d    = LAT_C;
      end else if (out_ready && (age_q != 2'd0)) begin
        age_d = age_q - 2'd1;
      end
      if (out_fire && cp_q.excp) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      age_q       <= 2'd0;
      ld_idx_q    <= '0;
      cp_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wr_idx_q    <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      br_q        <= 1'b0;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      age_q       <= age_d;
      ld_idx_q    <= ld_idx_d;
      if (in_fire) begin
        cp_q     <= dec_cp;
        rs_q     <= dec_rs;
        rt_q     <= dec_rt;
        wr_idx_q <= dec_wr;
        imm_q    <= dec_imm;
        pc_q     <= in_pc;
        br_q     <= dec_br;
        ld_q     <= dec_ld;
        st_q     <= dec_st;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_cpath     = cp_q;
  assign out_rs        = rs_q;
  assign out_rt        = rt_q;
  assign out_wr_idx    = wr_idx_q;
  assign out_imm       = imm_q;
  assign out_pc        = pc_q;
  assign out_is_branch = br_q;
  assign out_is_load   = ld_q;
  assign out_is_store  = st_q;
  assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-computed bundles,
// a negedge monitor pops and compares on every output handoff.
module tb_decode_stage;
  import core_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_inst = '0;
  logic [31:0]        in_pc = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [CPATH_W-1:0] out_cpath;
  logic [4:0]         out_rs, out_rt, out_wr_idx;
  logic [31:0]        out_imm, out_pc;
  logic               out_is_branch, out_is_load, out_is_store;
  logic               halted;

  decode_stage #(.XLEN(32), .REG_AW(5), .LOAD_LAT(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_cpath     (out_cpath),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_wr_idx    (out_wr_idx),
    .out_imm       (out_imm),
    .out_pc        (out_pc),
    .out_is_branch (out_is_branch),
    .out_is_load   (out_is_load),
    .out_is_store  (out_is_store),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CPATH_W-1:0] cp;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         wr;
    logic [31:0]        imm;
    logic [31:0]        pc;
    logic               br;
    logic               ld;
    logic               st;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  localparam logic [31:0] I_ADDI1 = 32'h20080005;
  localparam logic [31:0] I_ADDI2 = 32'h2108FFFF;
  localparam logic [31:0] I_ANDI  = 32'h3108FFFF;
  localparam logic [31:0] I_ADDZ  = 32'h20000007;
  localparam logic [31:0] I_BEQ   = 32'h11090003;
  localparam logic [31:0] I_LW    = 32'h8D280000;
  localparam logic [31:0] I_ADD   = 32'h01095020;
  localparam logic [31:0] I_ADD2  = 32'h014B6020;
  localparam logic [31:0] I_ILL   = 32'hFC000000;

  function automatic logic [CPATH_W-1:0] cpf(input reg_src_e s, input reg_dst_e d,
                                            input logic w, input logic [5:0] op,
                                            input alu_src_e a, input logic ex);
    return {s, d, w, op, a, ex};
  endfunction

  function automatic exp_t mk(input logic [CPATH_W-1:0] cp, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] wr,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic br, input logic ld, input logic st);
    exp_t e;
    e.cp = cp; e.rs = rs; e.rt = rt; e.wr = wr; e.imm = imm; e.pc = pc;
    e.br = br; e.ld = ld; e.st = st;
    return e;
  endfunction

  function automatic exp_t e_addi1(input logic [31:0] pc);
    return mk(cpf(RSRC_ALU, RDST_RT, 1'b1, FN_ADD, ASRC_SEXT, 1'b0), 5'd0, 5'd8, 5'd8,
              32'h00000005, pc, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_addi2(input logic [31:0] pc);
    return mk(cpf(RSRC_ALU, RDST_RT, 1'b1, FN_ADD, ASRC_SEXT, 1'b0), 5'd8, 5'd8, 5'd8,
              32'hFFFFFFFF, pc, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_andi(input logic [31:0] pc);
    return mk(cpf(RSRC_ALU, RDST_RT, 1'b1, FN_AND, ASRC_ZEXT, 1'b0), 5'd8, 5'd8, 5'd8,
              32'h0000FFFF, pc, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_lw(input logic [31:0] pc);
    return mk(cpf(RSRC_MEM, RDST_RT, 1'b1, FN_ADD, ASRC_SEXT, 1'b0), 5'd9, 5'd8, 5'd8,
              32'h00000000, pc, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic exp_t e_add(input logic [31:0] pc);
    return mk(cpf(RSRC_ALU, RDST_RD, 1'b1, FN_ADD, ASRC_REG, 1'b0), 5'd8, 5'd9, 5'd10,
              32'h00005020, pc, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_add2(input logic [31:0] pc);
    return mk(cpf(RSRC_ALU, RDST_RD, 1'b1, FN_ADD, ASRC_REG, 1'b0), 5'd10, 5'd11, 5'd12,
              32'h00006020, pc, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input exp_t e);
    expq.push_back(e);
    pushed++;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  // Called at posedge+1; returns at the next posedge+1 after the handshake.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e,
                      output int waits);
    waits = 0;
    drive(inst, pc);
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waits++;
      if (waits > 50) break;
    end
    if (waits > 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pc=%0h actual=stalled required=accepted", pc);
    end else begin
      push(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual_pc=%0h required=no_output", out_pc);
      end else begin
        e = expq.pop_front();
        popped++;
        chk("mon_cpath", 64'(out_cpath), 64'(e.cp));
        chk("mon_idx", 64'({out_rs, out_rt, out_wr_idx}), 64'({e.rs, e.rt, e.wr}));
        chk("mon_imm", 64'(out_imm), 64'(e.imm));
        chk("mon_pc", 64'(out_pc), 64'(e.pc));
        chk("mon_class", 64'({out_is_branch, out_is_load, out_is_store}),
            64'({e.br, e.ld, e.st}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    exp_t ex_x;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ctl", 64'({out_valid, halted, out_is_branch, out_is_load, out_is_store}), 64'd0);
    chk("rst_bundle", 64'({out_cpath, out_rs, out_rt, out_wr_idx}), 64'd0);
    chk("rst_imm_pc", {out_imm, out_pc}, 64'd0);
    @(posedge clk);
    #1;

    send(I_ADDI1, 32'h100, e_addi1(32'h100), w);
    send(I_ADDI2, 32'h104, e_addi2(32'h104), w);
    chk("b2b_wait", 64'(w), 64'd0);
    send(I_ANDI, 32'h108, e_andi(32'h108), w);
    send(I_ADDZ, 32'h10C, mk(cpf(RSRC_ALU, RDST_RT, 1'b0, FN_ADD, ASRC_SEXT, 1'b0),
                             5'd0, 5'd0, 5'd0, 32'h7, 32'h10C, 1'b0, 1'b0, 1'b0), w);
    send(I_BEQ, 32'h110, mk(cpf(RSRC_ALU, RDST_NONE, 1'b0, FN_SUB, ASRC_REG, 1'b0),
                            5'd8, 5'd9, 5'd0, 32'h3, 32'h110, 1'b1, 1'b0, 1'b0), w);
    idle(2);

    // load-use: lw then dependent add
    drive(I_LW, 32'h200);
    @(negedge clk);
    chk("lu_ld_acc", 64'(in_ready), 64'd1);
    if (in_ready) push(e_lw(32'h200));
    @(posedge clk);
    #1 drive(I_ADD, 32'h204);
    @(negedge clk);
    chk("lu_stall", 64'(in_ready), 64'd0);
    chk("lu_ld_out", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lu_bubble", 64'(out_valid), 64'd0);
    chk("lu_resume", 64'(in_ready), 64'd1);
    if (in_ready) push(e_add(32'h204));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lu_add_out", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    send(I_LW, 32'h210, e_lw(32'h210), w);
    send(I_ADD2, 32'h214, e_add2(32'h214), w);
    chk("indep_nowait", 64'(w), 64'd0);
    idle(2);

    // backpressure
    out_ready = 1'b0;
    ex_x = e_addi1(32'h300);
    send(I_ADDI1, 32'h300, ex_x, w);
    drive(I_ANDI, 32'h304);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", {out_pc, out_imm}, {ex_x.pc, ex_x.imm});
      chk("bp_hold_cp", 64'({out_cpath, out_wr_idx}), 64'({ex_x.cp, ex_x.wr}));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'(in_ready), 64'd1);
    if (in_ready) push(e_andi(32'h304));
    @(posedge clk);
    #1 in_valid = 1'b0;
    send(I_ADDI2, 32'h308, e_addi2(32'h308), w);
    idle(2);

    // illegal opcode -> halt, released by flush
    send(I_ILL, 32'h400, mk(cpf(RSRC_ALU, RDST_NONE, 1'b0, 6'h00, ASRC_REG, 1'b1),
                            5'd0, 5'd0, 5'd0, 32'h0, 32'h400, 1'b0, 1'b0, 1'b0), w);
    @(negedge clk);
    chk("ill_not_yet_halted", 64'(halted), 64'd0);
    @(posedge clk);
    #1 drive(I_ADDI1, 32'h404);
    repeat (4) begin
      @(negedge clk);
      chk("halt_flag", 64'(halted), 64'd1);
      chk("halt_in_ready", 64'(in_ready), 64'd0);
      chk("halt_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("unhalt", 64'(halted), 64'd0);
    chk("unhalt_ready", 64'(in_ready), 64'd1);
    if (in_ready) push(e_addi1(32'h404));
    @(posedge clk);
    #1 in_valid = 1'b0;
    idle(2);

    // flush while a load-use stall is held under backpressure
    out_ready = 1'b0;
    drive(I_LW, 32'h500);
    @(negedge clk);
    chk("fl_ld_acc", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 drive(I_ADD, 32'h504);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_stall", 64'(in_ready), 64'd0);
    chk("fl_ld_held", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_ov", 64'(out_valid), 64'd0);
    chk("fl_nobubble", 64'(in_ready), 64'd1);
    if (in_ready) push(e_add(32'h504));
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_add_out", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    idle(1);

    // reset during a load-use stall
    send(I_LW, 32'h600, e_lw(32'h600), w);
    drive(I_ADD, 32'h604);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_pre_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_ctl", 64'({out_valid, halted, out_is_branch, out_is_load, out_is_store}), 64'd0);
    chk("mrst_bundle", 64'({out_cpath, out_rs, out_rt, out_wr_idx}), 64'd0);
    chk("mrst_imm_pc", {out_imm, out_pc}, 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(I_ADD, 32'h608, e_add(32'h608), w);
    chk("mrst_no_stale_hazard", 64'(w), 64'd0);
    idle(3);

    chk("sb_drain", 64'(expq.size()), 64'd0);
    chk("sb_count", 64'(popped), 64'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
